mem_pingpong_ctrl: RTL
======================

Name: mem_pingpong_ctrl

Overview:
- Initiator-side controller that drives mem_interface's double-buffered SRAM ports.
- Accepts 128-bit word pairs from a producer over a valid/ready stream and writes them into the write bank.
- Streams the read bank's pairs to a consumer over valid/ready, absorbing the 1-cycle SRAM read latency in a skid buffer.
- Owns sram_read_register and swaps banks when both the fill and the drain of a frame are complete.

Parameters:
- DATA_W, 128, width of each data word.
- ADDR_W, 8, SRAM word address width.
- FRAME_PAIRS, 128, word pairs per frame; legal range 1..2^(ADDR_W-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  producer pair valid
- wr_ready  out  1  controller accepts pair
- wr_data1  in  DATA_W  producer even word
- wr_data2  in  DATA_W  producer odd word
- rd_valid  out  1  consumer pair valid
- rd_ready  in  1  consumer accepts pair
- rd_data1  out  DATA_W  consumer even word
- rd_data2  out  DATA_W  consumer odd word
- frame_swap  out  1  one-cycle pulse on the cycle the banks swap
- waddress1  out  ADDR_W  to mem_interface
- waddress2  out  ADDR_W  to mem_interface
- wdata1  out  DATA_W  to mem_interface
- wdata2  out  DATA_W  to mem_interface
- raddress1  out  ADDR_W  to mem_interface
- raddress2  out  ADDR_W  to mem_interface
- rdata1  in  DATA_W  from mem_interface, valid 1 cycle after its raddress is sampled
- rdata2  in  DATA_W  from mem_interface, valid 1 cycle after its raddress is sampled
- sram_read_register  out  1  bank select: 0 = read SRAM0 / write SRAM1

Behaviour:
- Reset:
  - sram_read_register=0; all addresses, wdata and counters = 0.
  - wr_state=FILL; rd_state=DONE (no valid data in the read bank after reset); rd_valid=0; frame_swap=0; skid buffer empty.
- Write FSM, FILL:
  - wr_ready=1.
  - On a wr_valid&&wr_ready beat with wr_cnt=k: drive waddress1=2k, waddress2=2k+1, wdata1/2 from inputs (combinational); the write commits at that posedge; wr_cnt increments.
  - When wr_cnt reaches FRAME_PAIRS, go to DONE.
- Write FSM, DONE: wr_ready=0.
- Idle write cycles: mem_interface has no write enable, so outputs hold the last written address/data registers. Rewrites are idempotent. After reset or swap, address 0 is rewritten with 0 until the first beat; that is benign because the first beat overwrites it.
- Read FSM, DRAIN:
  - Issue pair j at raddress1=2j, raddress2=2j+1 when in-flight + skid occupancy < 2; iss_cnt increments.
  - Data returns next cycle into the 2-entry skid buffer; rd_valid = buffer non-empty.
  - Pop on rd_valid&&rd_ready; dlv_cnt increments.
  - Go to DONE when dlv_cnt reaches FRAME_PAIRS.
- Read FSM, DONE: no issue, rd_valid=0.
- Swap: on the cycle both FSMs are in DONE:
  - sram_read_register toggles at the posedge; frame_swap=1 for that cycle.
  - Counters clear; wr_state→FILL; rd_state→DRAIN.
  - Swap is not allowed while any read is in flight, which is guaranteed by the DONE condition.
- First frame: the read side is already DONE, so the first swap occurs right after the first fill completes.
- Ordering and throughput:
  - Pairs are delivered in address order with no drop or duplication under arbitrary rd_ready backpressure.
  - Throughput is 1 pair/cycle when rd_ready is held high.
- Simultaneous events:
  - A write beat and a read issue in the same cycle are independent (different banks).
  - No write beat can coincide with a swap cycle (wr_ready=0 in DONE).
- Asynchronous reset mid-frame: abandons both frames and returns to the reset state; the bank contents are untouched.

Decomposition:
- Package mem_pingpong_pkg:
  - wr_state_t (FILL, DONE), rd_state_t (DRAIN, DONE).
  - DATA_W/ADDR_W constants shared with mem_interface.
  - Pair struct {word1, word2}.
- Sub-module pair_skid_buf: 2-entry FIFO of pair struct with push / pop, ready / valid and occupancy output.

Test Plan:
- Reset then FRAME_PAIRS=4, push pairs (0x10+i, 0x20+i) i=0..3 back-to-back → wr_ready high 4 cycles then low; frame_swap pulses once; sram_read_register=1.
- Second frame: push 4 new pairs (0x30+i, 0x40+i) while the consumer holds rd_ready=1 → rd_data1/2 = 0x10..0x13 / 0x20..0x23 on consecutive cycles; second swap only after both sides finish; sram_read_register=0.
- rd_ready toggled 1,0,0,1,… → all 4 pairs delivered exactly once, in order; raddress never runs more than 2 ahead of delivered.
- Producer finishes fill while the consumer stalls rd_ready=0 for 20 cycles → no swap, wr_ready stays 0, then swap 1 cycle after the final pop.
- Assert rst mid-drain (after 2 pairs delivered) → rd_valid=0, sram_read_register=0, wr_ready=1 in the cycle after reset is released.
- FRAME_PAIRS=128 full frame → last write lands on waddress1=0xFE and waddress2=0xFF; no address wrap.

Source files
------------

// File: rtl/mem_pingpong_pkg.sv
// Shared types and constants for the ping-pong SRAM controller and mem_interface.
package mem_pingpong_pkg;

  localparam int unsigned MEM_DATA_W = 128;
  localparam int unsigned MEM_ADDR_W = 8;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_DONE = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_DRAIN = 1'b0,
    RD_DONE  = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] word1;
    logic [MEM_DATA_W-1:0] word2;
  } pair_t;

endpackage

// File: rtl/mem_pingpong_ctrl_skid.sv
// Two-entry FIFO of word pairs; absorbs the one-cycle SRAM read latency.
module pair_skid_buf
  import mem_pingpong_pkg::*;
#(
  parameter type T = pair_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  T           push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output T           pop_data,
  output logic [1:0] occupancy
);

  T           mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push_fire;
  logic       pop_fire;

  // Handshake decode and head-of-queue output
  always_comb begin
    push_ready = (count != 2'd2);
    pop_valid  = (count != 2'd0);
    push_fire  = push_valid && push_ready;
    pop_fire   = pop_valid && pop_ready;
    occupancy  = count;
    pop_data   = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= ~wr_ptr;
      if (pop_fire)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_fire} - {1'b0, pop_fire};
    end
  end

  // Entry storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_pingpong_ctrl.sv
// Ping-pong SRAM controller: fills the write bank from a producer stream,
// drains the read bank to a consumer, and swaps banks when both are done.
module mem_pingpong_ctrl
  import mem_pingpong_pkg::*;
#(
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned FRAME_PAIRS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              frame_swap,
  output logic [ADDR_W-1:0] waddress1,
  output logic [ADDR_W-1:0] waddress2,
  output logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] wdata2,
  output logic [ADDR_W-1:0] raddress1,
  output logic [ADDR_W-1:0] raddress2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic              sram_read_register
);

  typedef struct packed {
    logic [DATA_W-1:0] word1;
    logic [DATA_W-1:0] word2;
  } pair_w_t;

  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(FRAME_PAIRS - 1);
  localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_PAIRS);

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] iss_cnt;
  logic [ADDR_W-1:0] dlv_cnt;
  logic [ADDR_W-1:0] waddr1_q;
  logic [ADDR_W-1:0] waddr2_q;
  logic [DATA_W-1:0] wdata1_q;
  logic [DATA_W-1:0] wdata2_q;
  logic              inflight_q;
  logic              wr_fire;
  logic              rd_pop;
  logic              issue;
  logic              swap;
  logic [1:0]        load_after;
  logic [ADDR_W-1:0] beat_addr;

  logic              skid_push_ready;
  logic              skid_valid;
  logic [1:0]        skid_occ;
  pair_w_t           skid_in;
  pair_w_t           skid_out;

  // Handshakes, SRAM address/data muxing and read issue throttle
  always_comb begin
    wr_ready   = (wr_state == WR_FILL);
    wr_fire    = wr_valid && wr_ready;
    swap       = (wr_state == WR_DONE) && (rd_state == RD_DONE);
    frame_swap = swap;
    beat_addr  = {wr_cnt[ADDR_W-2:0], 1'b0};
    // Idle cycles replay the last registered write; mem_interface has no write enable
    waddress1  = wr_fire ? beat_addr          : waddr1_q;
    waddress2  = wr_fire ? (beat_addr | 1'b1) : waddr2_q;
    wdata1     = wr_fire ? wr_data1           : wdata1_q;
    wdata2     = wr_fire ? wr_data2           : wdata2_q;
    raddress1  = {iss_cnt[ADDR_W-2:0], 1'b0};
    raddress2  = {iss_cnt[ADDR_W-2:0], 1'b1};
    rd_valid   = skid_valid && (rd_state == RD_DRAIN);
    rd_pop     = rd_valid && rd_ready;
    rd_data1   = skid_out.word1;
    rd_data2   = skid_out.word2;
    // Counting this cycle's pop keeps one pair per cycle with rd_ready held high
    load_after = skid_occ + {1'b0, inflight_q} - {1'b0, rd_pop};
    issue      = (rd_state == RD_DRAIN) && (iss_cnt != FRAME_CNT) && (load_after < 2'd2);
    skid_in    = '{word1: rdata1, word2: rdata2};
  end

  // Write FSM: accept FRAME_PAIRS beats, then wait for the swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= WR_FILL;
      wr_cnt   <= '0;
      waddr1_q <= '0;
      waddr2_q <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
    end else if (swap) begin
      wr_state <= WR_FILL;
      wr_cnt   <= '0;
      waddr1_q <= '0;
      waddr2_q <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
    end else if (wr_fire) begin
      waddr1_q <= beat_addr;
      waddr2_q <= beat_addr | 1'b1;
      wdata1_q <= wr_data1;
      wdata2_q <= wr_data2;
      wr_cnt   <= wr_cnt + 1'b1;
      if (wr_cnt == LAST_PAIR) wr_state <= WR_DONE;
    end
  end

  // Read FSM: issue reads, count deliveries, finish after FRAME_PAIRS pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state   <= RD_DONE;
      iss_cnt    <= '0;
      dlv_cnt    <= '0;
      inflight_q <= 1'b0;
    end else if (swap) begin
      rd_state   <= RD_DRAIN;
      iss_cnt    <= '0;
      dlv_cnt    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) iss_cnt <= iss_cnt + 1'b1;
      if (rd_pop) begin
        dlv_cnt <= dlv_cnt + 1'b1;
        if (dlv_cnt == LAST_PAIR) rd_state <= RD_DONE;
      end
    end
  end

  // Bank select toggles on every swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sram_read_register <= 1'b0;
    else if (swap) sram_read_register <= ~sram_read_register;
  end

  pair_skid_buf #(
    .T(pair_w_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_valid(inflight_q),
    .push_ready(skid_push_ready),
    .push_data (skid_in),
    .pop_valid (skid_valid),
    .pop_ready (rd_pop),
    .pop_data  (skid_out),
    .occupancy (skid_occ)
  );

  // The issue throttle guarantees returning data always finds a free entry
  a_skid_room : assert property (@(posedge clk) disable iff (rst) inflight_q |-> skid_push_ready);

endmodule
